sketch_mem_arbiter: RTL and testbench
=====================================

# sketch_mem_arbiter

Two-port arbiter that shares the single SDRAM master port of the sketch system between the VGA line-fetch engine (burst reads, high priority) and the accelerometer-driven pixel-draw engine (single read or write). It sits between both engines and the Avalon-MM slave of the SDRAM controller. It sequences pipelined reads, counts returning data and bounds starvation of the draw port.

## Interface
- ADDR_W, 24, word address width of the SDRAM slave
- DATA_W, 16, data width
- BURST_MAX, 8, maximum words per fetch request
- STARVE_LIMIT, 4, consecutive fetch grants allowed while draw is pending
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- f_req  in  1  fetch request; held until f_grant
- f_addr  in  ADDR_W  fetch base address, latched at acceptance
- f_len  in  $clog2(BURST_MAX+1)  words to fetch, latched at acceptance
- f_grant  out  1  one-cycle pulse, first issue cycle of a fetch
- f_rvalid  out  1  fetch read word valid
- f_rdata  out  DATA_W  fetch read word
- f_done  out  1  one-cycle pulse with last f_rvalid
- d_req  in  1  draw request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  draw address
- d_wdata  in  DATA_W  draw write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  draw read data, valid with d_ack on reads
- m_address  out  ADDR_W  master address
- m_read  out  1  master read strobe
- m_write  out  1  master write strobe
- m_writedata  out  DATA_W  master write data
- m_waitrequest  in  1  slave stall
- m_readdata  in  DATA_W  slave read data
- m_readdatavalid  in  1  slave read data valid; latency variable, order preserved

## Operation
- States: IDLE, F_ISSUE, F_DRAIN, D_ISSUE, D_WAIT.
- IDLE: requests sampled. Only f_req: go F_ISSUE. Only d_req: go D_ISSUE. Both: fetch wins unless starve_cnt == STARVE_LIMIT, then draw wins.
- starve_cnt: +1 (saturating at STARVE_LIMIT) on each fetch grant while d_req high; cleared on draw grant.
- Fetch acceptance latches f_addr and len = clamp(f_len, 1, BURST_MAX). f_len 0 is treated as 1; f_len > BURST_MAX is treated as BURST_MAX.
- F_ISSUE: m_read=1, m_address = base + issued, modulo 2^ADDR_W. issued increments on each cycle with m_read && !m_waitrequest. Last word accepted: go F_DRAIN.
- Return counting is active in F_ISSUE and F_DRAIN. Each m_readdatavalid drives f_rvalid=1 and f_rdata=m_readdata in the same cycle and increments returned. When returned reaches len, f_done pulses with that word and the FSM goes to IDLE.
- D_ISSUE: m_address=d_addr, m_read=!d_we, m_write=d_we, m_writedata=d_wdata. On !m_waitrequest:
  - Write: d_ack pulses in that cycle, then IDLE.
  - Read: go D_WAIT.
- D_WAIT: on m_readdatavalid, d_ack=1 and d_rdata=m_readdata; next state IDLE.
- m_readdatavalid in IDLE is discarded, e.g. stale returns after reset.
- A requester drops its req the cycle after it sees f_grant or d_ack. Every transaction lasts at least 2 cycles, so no double grant occurs.

## Timing
- Reset: state IDLE, starve_cnt 0, issued/returned 0. All outputs 0: f_grant, f_rvalid, f_done, d_ack, m_read, m_write, m_address, m_writedata, f_rdata, d_rdata.
- Reset mid-transaction: immediate abort, strobes drop asynchronously, no done or ack is generated.
- Request in IDLE at cycle N puts the first master strobe at N+1. f_grant is registered and coincides with the first m_read.
- With zero waitrequest, a fetch of len words occupies the bus for len issue cycles. Back-to-back reads occur with no bubbles.
- Strobes and m_address are registered and held stable while m_waitrequest=1.
- After f_done or d_ack, exactly one IDLE cycle precedes the next grant.
- m_read and m_write are never high simultaneously. Neither is high outside the ISSUE states.

## Test plan
- Single fetch: f_addr=0x100, f_len=4, no waitrequest, readdata latency 2. Required: m_read for 4 cycles at 0x100–0x103; f_rvalid ×4 with matching data; f_done on the 4th word; IDLE.
- Draw write under stall: d_we=1, d_addr=0x2A, d_wdata=0xBEEF, waitrequest high for 3 cycles. Required: m_write held for 4 cycles with stable address and data; d_ack in the accept cycle.
- Contention and starvation bound: f_req held continuously with f_len=2 and d_req high. Required: 4 fetch grants, then draw granted; starve_cnt returns to 0.
- Boundary lengths and wrap:
  - f_len=0 gives 1 read.
  - f_len=15 gives 8 reads.
  - f_addr=0xFFFFFE, len 4 gives addresses FFFFFE, FFFFFF, 000000, 000001.
- Reset mid-fetch after 2 of 8 returns, with late readdatavalid arriving after reset. Required: all outputs 0; no f_rvalid or f_done; the next d_req read completes with correct d_rdata.

Source files
------------

// File: rtl/sketch_mem_arbiter_if.sv
// Fetch, draw and Avalon-MM master bundle of the sketch SDRAM arbiter.
// master = arbiter side, slave = requesters plus SDRAM controller side.
interface sketch_mem_arbiter_if #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int BURST_MAX = 8
);
   localparam int LEN_W = $clog2(BURST_MAX + 1);

   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic [LEN_W-1:0]  f_len;
   logic              f_grant;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic              f_done;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] m_address;
   logic              m_read;
   logic              m_write;
   logic [DATA_W-1:0] m_writedata;
   logic              m_waitrequest;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;

   modport master (
      input  f_req, f_addr, f_len,
      output f_grant, f_rvalid, f_rdata, f_done,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata,
      output m_address, m_read, m_write, m_writedata,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   modport slave (
      output f_req, f_addr, f_len,
      input  f_grant, f_rvalid, f_rdata, f_done,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  m_address, m_read, m_write, m_writedata,
      output m_waitrequest, m_readdata, m_readdatavalid
   );
endinterface

// File: rtl/sketch_mem_arbiter.sv
// Shares the SDRAM master between VGA burst fetch and pixel draw.
// Fetch has priority; draw wins after STARVE_LIMIT fetch grants.
module sketch_mem_arbiter #(
   parameter int ADDR_W       = 24,
   parameter int DATA_W       = 16,
   parameter int BURST_MAX    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   sketch_mem_arbiter_if.master bus
);
   localparam int LEN_W = $clog2(BURST_MAX + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE, F_ISSUE, F_DRAIN, D_ISSUE, D_WAIT
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued;
   logic [LEN_W-1:0]  returned;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic              grant_q;
   logic [STV_W-1:0]  starve_cnt;
   logic [LEN_W-1:0]  len_clamp;
   logic              go_f;
   logic              go_d;
   logic              f_acc;
   logic              f_last_acc;
   logic              f_ret;
   logic              f_last_ret;
   logic              starved;

   // Bound the requested burst length into 1..BURST_MAX.
   always_comb begin
      len_clamp = bus.f_len;
      if (bus.f_len == '0)
         len_clamp = LEN_W'(1);
      else if (bus.f_len > LEN_W'(BURST_MAX))
         len_clamp = LEN_W'(BURST_MAX);
   end

   // State register; reset aborts any transaction at once.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Arbitration, issue/return bookkeeping and next state.
   always_comb begin
      state_nx   = state;
      go_f       = 1'b0;
      go_d       = 1'b0;
      starved    = (starve_cnt == STV_W'(STARVE_LIMIT));
      f_acc      = (state == F_ISSUE) && !bus.m_waitrequest;
      f_last_acc = f_acc && (issued == len_q - LEN_W'(1));
      f_ret      = ((state == F_ISSUE) || (state == F_DRAIN))
                   && bus.m_readdatavalid;
      f_last_ret = f_ret && (returned == len_q - LEN_W'(1));
      unique case (state)
         IDLE: begin
            if (bus.f_req && !(bus.d_req && starved)) begin
               go_f     = 1'b1;
               state_nx = F_ISSUE;
            end else if (bus.d_req) begin
               go_d     = 1'b1;
               state_nx = D_ISSUE;
            end
         end
         F_ISSUE: begin
            if (f_last_ret)
               state_nx = IDLE;
            else if (f_last_acc)
               state_nx = F_DRAIN;
         end
         F_DRAIN: begin
            if (f_last_ret)
               state_nx = IDLE;
         end
         D_ISSUE: begin
            if (!bus.m_waitrequest)
               state_nx = we_q ? IDLE : D_WAIT;
         end
         D_WAIT: begin
            if (bus.m_readdatavalid)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the granted request and count issued/returned words.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         base_q     <= '0;
         len_q      <= '0;
         issued     <= '0;
         returned   <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         grant_q    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         grant_q <= go_f;
         if (go_f) begin
            base_q   <= bus.f_addr;
            len_q    <= len_clamp;
            issued   <= '0;
            returned <= '0;
            if (bus.d_req && !starved)
               starve_cnt <= starve_cnt + STV_W'(1);
         end else if (go_d) begin
            base_q     <= bus.d_addr;
            we_q       <= bus.d_we;
            wdata_q    <= bus.d_wdata;
            starve_cnt <= '0;
         end else begin
            if (f_acc)
               issued <= issued + LEN_W'(1);
            if (f_ret)
               returned <= returned + LEN_W'(1);
         end
      end
   end

   // Outputs decoded from registered state; read data gated by valid.
   always_comb begin
      logic rd_s;
      logic wr_s;
      rd_s = (state == F_ISSUE) || ((state == D_ISSUE) && !we_q);
      wr_s = (state == D_ISSUE) && we_q;
      bus.f_grant     = grant_q;
      bus.f_rvalid    = f_ret;
      bus.f_rdata     = f_ret ? bus.m_readdata : '0;
      bus.f_done      = f_last_ret;
      bus.d_ack       = (wr_s && !bus.m_waitrequest)
                        || ((state == D_WAIT) && bus.m_readdatavalid);
      bus.d_rdata     = ((state == D_WAIT) && bus.m_readdatavalid)
                        ? bus.m_readdata : '0;
      bus.m_read      = rd_s;
      bus.m_write     = wr_s;
      bus.m_writedata = wr_s ? wdata_q : '0;
      bus.m_address   = '0;
      if (state == F_ISSUE)
         bus.m_address = base_q + ADDR_W'(issued);
      else if (state == D_ISSUE)
         bus.m_address = base_q;
   end
endmodule

// File: tb/tb_sketch_mem_arbiter.sv
// Directed bench for sketch_mem_arbiter with an SDRAM slave model.
// Expected words are queued at grant/request and popped on returns.
module tb_sketch_mem_arbiter;
   typedef struct {
      int          due;
      logic [15:0] data;
   } pend_t;
   typedef struct {
      logic [15:0] data;
      logic        last;
   } fexp_t;
   typedef struct {
      logic [23:0] addr;
      logic        we;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } dexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sketch_mem_arbiter_if #(
      .ADDR_W(24), .DATA_W(16), .BURST_MAX(8)
   ) bus ();

   sketch_mem_arbiter #(
      .ADDR_W(24), .DATA_W(16), .BURST_MAX(8), .STARVE_LIMIT(4)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [15:0] mem [int];
   pend_t       pend [$];
   fexp_t       exp_f [$];
   logic [23:0] exp_fa [$];
   dexp_t       exp_d [$];

   int cyc = 0;
   int lat = 2;
   int stall = 0;
   int f_left = 0;
   int frv_cnt = 0;
   int facc_cnt = 0;
   int fstb_cnt = 0;
   int fgrant_cnt = 0;
   int dack_cnt = 0;
   int wr_cycles = 0;
   int fg_at_ack = 0;
   int last_end = -1;
   bit cont = 1'b0;
   logic [23:0] fa = '0;
   logic [3:0]  fl = '0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mdata(input logic [23:0] a);
      if (mem.exists(int'(a)))
         return mem[int'(a)];
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic int nwords(input logic [3:0] l);
      if (l == 4'd0)
         return 1;
      if (l > 4'd8)
         return 8;
      return int'(l);
   endfunction

   // Slave model plus output monitor, once per cycle at the negedge.
   initial begin
      logic  strobe;
      logic  acc;
      pend_t p;
      fexp_t fe;
      dexp_t de;
      bus.m_waitrequest   = 1'b0;
      bus.m_readdata      = '0;
      bus.m_readdatavalid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         strobe = bus.m_read || bus.m_write;
         bus.m_waitrequest = strobe && (stall > 0);
         if (bus.m_waitrequest)
            stall--;
         acc = strobe && !bus.m_waitrequest;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = p.data;
         end else begin
            bus.m_readdatavalid = 1'b0;
            bus.m_readdata      = '0;
         end
         if (bus.m_read && acc)
            pend.push_back('{cyc + lat, mdata(bus.m_address)});
         #1;
         if (bus.f_grant) begin
            int n;
            fgrant_cnt++;
            if (cont && last_end >= 0)
               chk("idle_gap", cyc - last_end, 2);
            n = nwords(fl);
            f_left = n;
            for (int i = 0; i < n; i++) begin
               logic [23:0] a;
               a = fa + 24'(i);
               exp_fa.push_back(a);
               exp_f.push_back('{mdata(a), i == n - 1});
            end
         end
         if (strobe)
            chk("rw_excl", 32'(bus.m_read & bus.m_write), 0);
         if (bus.m_read && f_left > 0) begin
            fstb_cnt++;
            chk("f_addr", bus.m_address, exp_fa[0]);
            if (acc) begin
               void'(exp_fa.pop_front());
               f_left--;
               facc_cnt++;
            end
         end else if (strobe) begin
            if (exp_d.size() == 0) begin
               chk("d_strobe_unexp", exp_d.size(), 1);
            end else begin
               chk("d_addr", bus.m_address, exp_d[0].addr);
               chk("d_wr", 32'(bus.m_write), 32'(exp_d[0].we));
               if (exp_d[0].we) begin
                  wr_cycles++;
                  chk("d_wdata", bus.m_writedata, exp_d[0].wdata);
               end
            end
         end
         if (bus.f_rvalid) begin
            frv_cnt++;
            if (exp_f.size() == 0) begin
               chk("f_rvalid_unexp", 32'(bus.f_rvalid), 0);
            end else begin
               fe = exp_f.pop_front();
               chk("f_rdata", bus.f_rdata, fe.data);
               chk("f_done", 32'(bus.f_done), 32'(fe.last));
               if (bus.f_done)
                  last_end = cyc;
            end
         end else if (bus.f_done) begin
            chk("f_done_stray", 32'(bus.f_done), 0);
         end
         if (bus.d_ack) begin
            dack_cnt++;
            last_end  = cyc;
            fg_at_ack = fgrant_cnt;
            if (exp_d.size() == 0) begin
               chk("d_ack_unexp", 32'(bus.d_ack), 0);
            end else begin
               de = exp_d.pop_front();
               if (de.we)
                  chk("d_ack_in_accept", 32'(bus.m_write && acc), 1);
               else
                  chk("d_rdata", bus.d_rdata, de.rdata);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_zero(input string pfx);
      chk({pfx, "_f_grant"},  32'(bus.f_grant),  0);
      chk({pfx, "_f_rvalid"}, 32'(bus.f_rvalid), 0);
      chk({pfx, "_f_done"},   32'(bus.f_done),   0);
      chk({pfx, "_d_ack"},    32'(bus.d_ack),    0);
      chk({pfx, "_m_read"},   32'(bus.m_read),   0);
      chk({pfx, "_m_write"},  32'(bus.m_write),  0);
      chk({pfx, "_m_addr"},   bus.m_address,     0);
      chk({pfx, "_m_wdata"},  bus.m_writedata,   0);
      chk({pfx, "_f_rdata"},  bus.f_rdata,       0);
      chk({pfx, "_d_rdata"},  bus.d_rdata,       0);
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic wait_fetch_idle();
      for (int k = 0; k < 200; k++) begin
         if (exp_f.size() == 0 && f_left == 0)
            break;
         step();
      end
      chk("f_drain_left", exp_f.size() + f_left, 0);
   endtask

   task automatic push_draw(input logic [23:0] a, input logic we,
                            input logic [15:0] wd);
      exp_d.push_back('{a, we, wd, mdata(a)});
      bus.d_addr  = a;
      bus.d_we    = we;
      bus.d_wdata = wd;
      bus.d_req   = 1'b1;
   endtask

   task automatic wait_dack(input int base);
      for (int k = 0; k < 300; k++) begin
         if (dack_cnt > base)
            break;
         step();
      end
      chk("d_ack_count", dack_cnt - base, 1);
   endtask

   task automatic do_fetch(input logic [23:0] a, input logic [3:0] l,
                           input int n, input int st);
      int a0;
      int r0;
      int s0;
      step();
      a0 = facc_cnt;
      r0 = frv_cnt;
      s0 = fstb_cnt;
      fa = a;
      fl = l;
      stall = st;
      bus.f_addr = a;
      bus.f_len  = l;
      bus.f_req  = 1'b1;
      step();
      chk("f_grant_next", 32'(bus.f_grant), 1);
      chk("m_read_next",  32'(bus.m_read),  1);
      bus.f_req = 1'b0;
      wait_fetch_idle();
      chk("f_accepts", facc_cnt - a0, n);
      chk("f_rvalids", frv_cnt - r0, n);
      chk("f_strobes", fstb_cnt - s0, n + st);
      repeat (2) step();
   endtask

   task automatic do_draw(input logic [23:0] a, input logic we,
                          input logic [15:0] wd, input int st);
      int b;
      int w0;
      step();
      b = dack_cnt;
      w0 = wr_cycles;
      stall = st;
      push_draw(a, we, wd);
      wait_dack(b);
      bus.d_req = 1'b0;
      if (we) begin
         chk("d_wr_cycles", wr_cycles - w0, st + 1);
         mem[int'(a)] = wd;
      end
      repeat (2) step();
   endtask

   initial begin
      int g0;
      int b;
      int r1;
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.f_len   = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      rst = 1'b1;
      repeat (2) step();
      chk_zero("rst");
      rst = 1'b0;
      repeat (2) step();

      lat = 2;
      do_fetch(24'h000100, 4'd4, 4, 0);

      do_draw(24'h00002A, 1'b1, 16'hBEEF, 3);
      do_draw(24'h00002A, 1'b0, 16'h0000, 1);

      step();
      cont = 1'b1;
      last_end = -1;
      fa = 24'h000300;
      fl = 4'd2;
      bus.f_addr = fa;
      bus.f_len  = fl;
      bus.f_req  = 1'b1;
      g0 = fgrant_cnt;
      b  = dack_cnt;
      push_draw(24'h000040, 1'b0, 16'h0000);
      wait_dack(b);
      bus.d_req = 1'b0;
      chk("starve_grants_1", fg_at_ack - g0, 4);
      repeat (7) step();
      g0 = fgrant_cnt;
      b  = dack_cnt;
      push_draw(24'h000041, 1'b0, 16'h0000);
      wait_dack(b);
      bus.d_req = 1'b0;
      bus.f_req = 1'b0;
      chk("starve_grants_2", fg_at_ack - g0, 4);
      wait_fetch_idle();
      cont = 1'b0;
      repeat (2) step();

      do_fetch(24'h000200, 4'd0, 1, 0);
      do_fetch(24'h000210, 4'd15, 8, 2);
      do_fetch(24'hFFFFFE, 4'd4, 4, 0);

      lat = 4;
      step();
      fa = 24'h000500;
      fl = 4'd8;
      bus.f_addr = fa;
      bus.f_len  = fl;
      bus.f_req  = 1'b1;
      r1 = frv_cnt;
      step();
      bus.f_req = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (frv_cnt - r1 >= 2)
            break;
         step();
      end
      chk("pre_rst_rvalids", frv_cnt - r1, 2);
      chk("pre_rst_m_read", 32'(bus.m_read), 1);
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      exp_f.delete();
      exp_fa.delete();
      f_left = 0;
      r1 = frv_cnt;
      repeat (3) step();
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (pend.size() == 0)
            break;
         step();
      end
      chk("stale_drained", pend.size(), 0);
      repeat (2) step();
      chk("no_rvalid_after_rst", frv_cnt - r1, 0);
      lat = 2;
      do_draw(24'h000500, 1'b0, 16'h0000, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
